// File: rtl/data_cache_pkg.sv
// rtl/data_cache_pkg.sv - shared geometry, state encoding and address-field helpers for data_cache
package data_cache_pkg;

    localparam int INDEX_BITS  = 4;
    localparam int OFFSET_BITS = 2;
    localparam int TAG_BITS    = 30 - INDEX_BITS - OFFSET_BITS;
    localparam int LINES       = 1 << INDEX_BITS;
    localparam int WORDS       = 1 << OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_e;

    function automatic logic [TAG_BITS-1:0] addr_tag(input logic [31:0] addr);
        return addr[31:INDEX_BITS+OFFSET_BITS+2];
    endfunction

    function automatic logic [INDEX_BITS-1:0] addr_index(input logic [31:0] addr);
        return addr[INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2];
    endfunction

    function automatic logic [OFFSET_BITS-1:0] addr_offset(input logic [31:0] addr);
        return addr[OFFSET_BITS+1:2];
    endfunction

    // Address of word 0 of the line holding addr.
    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return {addr[31:OFFSET_BITS+2], {(OFFSET_BITS+2){1'b0}}};
    endfunction

endpackage

// File: rtl/data_cache_array.sv
// rtl/data_cache_array.sv - valid/tag/data storage with asynchronous read and single-word write
module data_cache_array
    import data_cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_BITS-1:0]  index,
    input  logic [OFFSET_BITS-1:0] rd_offset,
    output logic                   rd_valid,
    output logic [TAG_BITS-1:0]    rd_tag,
    output logic [31:0]            rd_word,
    input  logic                   clr_en,
    input  logic                   set_en,
    input  logic [TAG_BITS-1:0]    set_tag,
    input  logic                   wr_en,
    input  logic [OFFSET_BITS-1:0] wr_offset,
    input  logic [31:0]            wr_data
);

    logic [LINES-1:0]    valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES*WORDS];

    assign rd_valid = valid_q[index];
    assign rd_tag   = tag_mem[index];
    assign rd_word  = data_mem[{index, rd_offset}];

    // Clear on refill entry so a half-filled line never hits; set once the last word lands.
    always_comb begin
        valid_d = valid_q;
        if (clr_en) begin
            valid_d[index] = 1'b0;
        end
        if (set_en) begin
            valid_d[index] = 1'b1;
        end
    end

    // Valid bits are the only storage that reset touches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; stale contents are masked by the valid bit.
    always_ff @(posedge clk) begin
        if (set_en) begin
            tag_mem[index] <= set_tag;
        end
        if (wr_en) begin
            data_mem[{index, wr_offset}] <= wr_data;
        end
    end

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through no-write-allocate data cache: FSM, latches, burst counter
module data_cache
    import data_cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    state_e                 state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [31:0]            mem_addr_q, mem_addr_d;
    logic [31:0]            mem_wdata_q, mem_wdata_d;

    logic [31:0]            lookup_addr;
    logic [INDEX_BITS-1:0]  lookup_index;
    logic [OFFSET_BITS-1:0] lookup_offset;
    logic                   rd_valid;
    logic [TAG_BITS-1:0]    rd_tag;
    logic [31:0]            rd_word;
    logic                   hit;
    logic                   clr_en, set_en, wr_en;
    logic [OFFSET_BITS-1:0] wr_offset;
    logic [31:0]            wr_data;
    logic                   unused_low_bits;

    // In IDLE the live CPU address probes the array; while stalled the latched copy owns it.
    assign lookup_addr     = (state_q == IDLE) ? cpu_addr : addr_q;
    assign lookup_index    = addr_index(lookup_addr);
    assign lookup_offset   = addr_offset(lookup_addr);
    assign hit             = rd_valid && (rd_tag == addr_tag(lookup_addr));
    assign unused_low_bits = ^lookup_addr[1:0];

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    data_cache_array u_array (
        .clk       (clk),
        .rst       (rst),
        .index     (lookup_index),
        .rd_offset (lookup_offset),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_word   (rd_word),
        .clr_en    (clr_en),
        .set_en    (set_en),
        .set_tag   (addr_tag(lookup_addr)),
        .wr_en     (wr_en),
        .wr_offset (wr_offset),
        .wr_data   (wr_data)
    );

    // Next-state, CPU handshake and array control; memory-side outputs are computed one cycle ahead.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_ready   = 1'b0;
        cpu_rdata   = '0;
        clr_en      = 1'b0;
        set_en      = 1'b0;
        wr_en       = 1'b0;
        wr_offset   = (state_q == REFILL) ? cnt_q : lookup_offset;
        wr_data     = (state_q == REFILL) ? mem_rdata : wdata_q;

        case (state_q)
            IDLE: begin
                if (!cpu_req) begin
                    cpu_ready = 1'b1;
                end else if (cpu_we) begin
                    addr_d      = {cpu_addr[31:2], 2'b00};
                    wdata_d     = cpu_wdata;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {cpu_addr[31:2], 2'b00};
                    mem_wdata_d = cpu_wdata;
                    state_d     = WRITE;
                end else if (hit) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = rd_word;
                end else begin
                    addr_d     = line_base(cpu_addr);
                    cnt_d      = '0;
                    clr_en     = 1'b1;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = line_base(cpu_addr);
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                if (mem_ack) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (&cnt_q) begin
                        set_en    = 1'b1;
                        mem_req_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        mem_addr_d = addr_q + 32'({cnt_d, 2'b00});
                    end
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    cpu_ready = 1'b1;
                    wr_en     = hit;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latches, burst counter and registered memory-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the CPU memory stage and a slow word-wide backing memory.
- Read hits complete in the same cycle the request is presented.
- Read misses refill a whole line with a burst of single-word handshakes. Writes always go through to memory.
- cpu_ready low is the memory-stage stall: it freezes the whole pipeline.

Parameters:
INDEX_BITS, 4, log2 of line count (16 lines)
OFFSET_BITS, 2, log2 of words per line (4 words)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
cpu_req  input  1  memory-stage access valid (LW or SW)
cpu_we  input  1  1 = store, 0 = load
cpu_addr  input  32  byte address; bits [1:0] ignored
cpu_wdata  input  32  store data
cpu_rdata  output  32  load data, valid when cpu_ready && cpu_req && !cpu_we
cpu_ready  output  1  access completes this cycle; 0 = stall pipeline
mem_req  output  1  backing-memory request
mem_we  output  1  backing-memory write
mem_addr  output  32  word-aligned backing-memory address
mem_wdata  output  32  backing-memory write data
mem_rdata  input  32  backing-memory read data, valid with mem_ack
mem_ack  input  1  one-cycle acknowledge, one per word

Behaviour:
- Address split:
  - offset = addr[OFFSET_BITS+1:2]
  - index = the next INDEX_BITS bits
  - tag = addr[31:INDEX_BITS+OFFSET_BITS+2]
- Storage: per line, 1 valid bit, 1 tag, 2^OFFSET_BITS data words. Reads are asynchronous.
- hit = valid[index] && tag[index] == tag(cpu_addr).
- States: IDLE, REFILL, WRITE.
- IDLE:
  - cpu_req=0 -> cpu_ready=1, no memory activity.
  - Load hit -> cpu_ready=1 combinationally; cpu_rdata = stored word; stay IDLE.
  - Load miss -> cpu_ready=0. Latch line base address (offset cleared) and clear the word counter. Next state REFILL.
  - Store (hit or miss) -> cpu_ready=0. Latch address and data. Next state WRITE.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = latched base + 4*counter.
  - On mem_ack: write mem_rdata into word[counter] and increment counter.
  - On ack of the last word: set valid, write tag, go IDLE.
  - The stalled load then hits on the following cycle. Miss latency = 4 acks + 1 cycle.
  - valid[index] is cleared on REFILL entry, so a partially filled line is never reported as a hit.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr/mem_wdata from latches.
  - On mem_ack: cpu_ready=1 in that same cycle. If the latched address hits, update the cached word. Go IDLE.
  - A store miss leaves the cache unchanged.
- In REFILL and WRITE, cpu_ready=0 except as stated above. CPU inputs are ignored; the latched copies are used.
- mem_req, mem_addr and mem_wdata stay stable from request until the acked cycle. mem_req drops the cycle after the final ack.
- cpu_rdata = 0 whenever it is not a load completion.
- mem_ack outside REFILL/WRITE is ignored.
- Reset (rst=0, any time including mid-burst):
  - state=IDLE, all valid bits=0, counter=0, latches=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Data and tag arrays are not reset.
  - An aborted refill leaves its line invalid.
- Address arithmetic is 32-bit; the counter wraps only at burst end.

Decomposition:
- Shared package holds:
  - state encoding IDLE/REFILL/WRITE
  - localparams TAG_BITS = 30-INDEX_BITS-OFFSET_BITS and LINES
  - tag/index/offset extraction helpers
- One sub-module is natural: data_cache_array, containing valid/tag/data storage with async read, line valid clear/set, and word write.
- The FSM, latches and counter stay in data_cache.

Test Plan:
- Reset, then load 0x100 -> cpu_ready=0. mem_addr sequence 0x100,0x104,0x108,0x10C (memory data 0xA0..0xA3). cpu_ready=1 one cycle after the 4th ack with cpu_rdata=0xA0.
- After the above, load 0x108 -> same-cycle cpu_ready=1, cpu_rdata=0xA2, mem_req stays 0.
- Store 0xDEADBEEF to 0x104 (hit) -> mem_we=1, mem_addr=0x104. cpu_ready=1 on the ack cycle. A following load 0x104 hits with 0xDEADBEEF.
- Store to 0x500 (miss, no allocate), then load 0x500 -> the store causes no refill. The load misses and refills 0x500..0x50C.
- Load 0x1100 (same index as 0x100, different tag) -> miss, refill evicts the line. A later load 0x100 misses again.
- Assert rst=0 after the 2nd ack of a refill at 0x200 -> mem_req=0 immediately. After release, load 0x200 misses and restarts the burst at word 0.
